mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arbiter_pick.sv | 31 +++
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds the FSM state enum, port indices and the fetch-port Func3.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    localparam logic [2:0] FUNC3_LW = 3'b010;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational arbitration decision between fetch and data ports.
// Ports: req_if, req_d (requests), last (last grant, round-robin only),
// grant (winning port index). Policy macro: MEM_ARB_ROUND_ROBIN_EN.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic req_if,
    input  logic req_d,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic last,
`endif
    output logic grant
);

    always_comb begin
        grant = PORT_IF;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        // On conflict the port not served last time wins.
        if (req_if && req_d) begin
            grant = ~last;
        end else if (req_d) begin
            grant = PORT_D;
        end
`else
        if (req_d) begin
            grant = PORT_D;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one shared memory.
// Ports: Clock/Reset, if_* (fetch), d_* (data), mem_* (memory side),
// timeout_err (sticky). Macro MEM_ARB_ROUND_ROBIN_EN selects
// round-robin arbitration; otherwise the data port has fixed priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ADDR_W         = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              if_Read,
    input  logic [ADDR_W-1:0] if_Address,
    output logic [31:0]       if_Read_data,
    output logic              if_busywait,
    input  logic              d_Read,
    input  logic              d_Write,
    input  logic [ADDR_W-1:0] d_Address,
    input  logic [31:0]       d_Write_data,
    input  logic [2:0]        d_Func3,
    output logic [31:0]       d_Read_data,
    output logic              d_busywait,
    output logic              mem_Read,
    output logic              mem_Write,
    output logic [ADDR_W-1:0] mem_Address,
    output logic [31:0]       mem_Write_data,
    output logic [2:0]        mem_Func3,
    input  logic [31:0]       mem_Read_data,
    input  logic              mem_busywait,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q;
    state_t            state_d;
    logic              grant_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        func3_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       rdata_if_q;
    logic [31:0]       rdata_d_q;
    logic              terr_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              last_q;
`endif

    logic        req_if;
    logic        req_d;
    logic        pick;
    logic        in_acc;
    logic        tmo;
    logic [31:0] cap_data;

    assign req_if = if_Read;
    assign req_d  = d_Read | d_Write;
    assign in_acc = (state_q == ACCESS);

    // Timeout wins only while memory is still stalling on the last edge.
    assign tmo      = mem_busywait && (cnt_q == CNT_LAST);
    assign cap_data = tmo ? 32'h0 : mem_Read_data;

    mem_arb_pick u_pick (
        .req_if (req_if),
        .req_d  (req_d),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last   (last_q),
`endif
        .grant  (pick)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_if || req_d) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!mem_busywait || tmo) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            grant_q    <= PORT_IF;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            func3_q    <= 3'b000;
            cnt_q      <= '0;
            rdata_if_q <= 32'h0;
            rdata_d_q  <= 32'h0;
            terr_q     <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q     <= PORT_IF;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && (req_if || req_d)) begin
                grant_q <= pick;
                cnt_q   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                last_q  <= pick;
`endif
                if (pick == PORT_D) begin
                    // Read and write together count as a write.
                    write_q <= d_Write;
                    addr_q  <= d_Address;
                    wdata_q <= d_Write_data;
                    func3_q <= d_Func3;
                end else begin
                    write_q <= 1'b0;
                    addr_q  <= if_Address;
                    wdata_q <= 32'h0;
                    func3_q <= FUNC3_LW;
                end
            end
            if (in_acc) begin
                cnt_q <= cnt_q + 1'b1;
                if (state_d == RESP) begin
                    // A requester that has walked away gets nothing.
                    if (grant_q == PORT_D && req_d) begin
                        rdata_d_q <= cap_data;
                    end
                    if (grant_q == PORT_IF && req_if) begin
                        rdata_if_q <= cap_data;
                    end
                    if (tmo) begin
                        terr_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign mem_Read       = in_acc && !write_q;
    assign mem_Write      = in_acc && write_q;
    assign mem_Address    = in_acc ? addr_q : '0;
    assign mem_Write_data = in_acc ? wdata_q : 32'h0;
    assign mem_Func3      = in_acc ? func3_q : 3'b000;

    assign if_busywait = req_if &&
        !(state_q == RESP && grant_q == PORT_IF);
    assign d_busywait  = req_d &&
        !(state_q == RESP && grant_q == PORT_D);

    assign if_Read_data = rdata_if_q;
    assign d_Read_data  = rdata_d_q;
    assign timeout_err  = terr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed traffic on both ports,
// a small memory model, and a monitor that checks every response.
module tb_mem_arbiter;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        if_Read = 1'b0;
    logic [31:0] if_Address = 32'h0;
    logic [31:0] if_Read_data;
    logic        if_busywait;
    logic        d_Read = 1'b0;
    logic        d_Write = 1'b0;
    logic [31:0] d_Address = 32'h0;
    logic [31:0] d_Write_data = 32'h0;
    logic [2:0]  d_Func3 = 3'b010;
    logic [31:0] d_Read_data;
    logic        d_busywait;
    logic        mem_Read;
    logic        mem_Write;
    logic [31:0] mem_Address;
    logic [31:0] mem_Write_data;
    logic [2:0]  mem_Func3;
    logic [31:0] mem_Read_data;
    logic        mem_busywait;
    logic        timeout_err;

    always #5 Clock = ~Clock;

    mem_arbiter #(.TIMEOUT_CYCLES(64), .ADDR_W(32)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .if_Read        (if_Read),
        .if_Address     (if_Address),
        .if_Read_data   (if_Read_data),
        .if_busywait    (if_busywait),
        .d_Read         (d_Read),
        .d_Write        (d_Write),
        .d_Address      (d_Address),
        .d_Write_data   (d_Write_data),
        .d_Func3        (d_Func3),
        .d_Read_data    (d_Read_data),
        .d_busywait     (d_busywait),
        .mem_Read       (mem_Read),
        .mem_Write      (mem_Write),
        .mem_Address    (mem_Address),
        .mem_Write_data (mem_Write_data),
        .mem_Func3      (mem_Func3),
        .mem_Read_data  (mem_Read_data),
        .mem_busywait   (mem_busywait),
        .timeout_err    (timeout_err)
    );

    // Memory model
    logic [31:0] mem [0:63];
    int          wait_states = 0;
    bit          force_busy = 1'b0;
    int          stall_cnt = 0;
    int          acc_cyc = 0;
    logic [2:0]  last_f3 = 3'b000;

    assign mem_Read_data = mem[mem_Address[7:2]];
    assign mem_busywait  = force_busy ||
        ((mem_Read || mem_Write) && stall_cnt < wait_states);

    always @(posedge Clock) begin
        if (!Reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[0]  <= 32'hB000_0000;
            mem[1]  <= 32'hB000_0004;
            mem[2]  <= 32'hB000_0008;
            mem[8]  <= 32'hA000_0020;
            mem[9]  <= 32'hA000_0024;
            mem[10] <= 32'hA000_0028;
            mem[12] <= 32'h5555_AAAA;
            mem[13] <= 32'h7777_3434;
            mem[16] <= 32'h1234_5678;
            mem[17] <= 32'h0BAD_F00D;
            mem[18] <= 32'h0C0F_FEE0;
            stall_cnt <= 0;
        end else begin
            if (mem_Read || mem_Write) stall_cnt <= stall_cnt + 1;
            else stall_cnt <= 0;
            if ((mem_Read || mem_Write) && !mem_busywait) begin
                last_f3 <= mem_Func3;
                if (mem_Write) mem[mem_Address[7:2]] <= mem_Write_data;
            end
        end
    end

    always @(negedge Clock) begin
        if (mem_Read || mem_Write) acc_cyc <= acc_cyc + 1;
    end

    // Scoreboard
    typedef struct packed {
        logic        port;
        logic        chk;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic push(input logic p, input logic c,
                        input logic [31:0] d);
        exp_t e;
        e.port = p;
        e.chk  = c;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic got(input logic p, input logic [31:0] d);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL resp_unexpected port=%0d data=%h", p, d);
        end else begin
            e = exp_q.pop_front();
            if (e.port != p || (e.chk && e.data != d)) begin
                failures++;
                $display("FAIL resp port=%0d data=%h need port=%0d data=%h",
                         p, d, e.port, e.data);
            end
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge Clock);
            if (Reset) begin
                if (if_Read && !if_busywait) got(1'b0, if_Read_data);
                if ((d_Read || d_Write) && !d_busywait)
                    got(1'b1, d_Read_data);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%h need=%h", name, act, req);
        end
    endtask

    task automatic wait_resp(input bit port, output int t);
        t = 0;
        do begin
            @(negedge Clock);
            t++;
        end while ((port ? d_busywait : if_busywait) && t < 300);
        chk("wait_resp", 32'(port ? d_busywait : if_busywait), 32'h0);
    endtask

    task automatic drv_rd(input bit port, input int n,
                          input logic [31:0] base,
                          input logic [2:0] f3);
        int t;
        for (int k = 0; k < n; k++) begin
            if (port) begin
                d_Address = base + 32'(4 * k);
                d_Func3   = f3;
                d_Read    = 1'b1;
            end else begin
                if_Address = base + 32'(4 * k);
                if_Read    = 1'b1;
            end
            wait_resp(port, t);
            @(posedge Clock);
            #1;
        end
        if (port) d_Read = 1'b0;
        else if_Read = 1'b0;
    endtask

    task automatic drv_wr(input logic [31:0] a, input logic [31:0] d);
        int t;
        d_Address    = a;
        d_Write_data = d;
        d_Func3      = 3'b010;
        d_Read       = 1'b1;
        d_Write      = 1'b1;
        wait_resp(1'b1, t);
        @(posedge Clock);
        #1;
        d_Read  = 1'b0;
        d_Write = 1'b0;
    endtask

    initial begin : stim
        int t;
        int a0;

        // Reset state
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        chk("rst_mem_rd", 32'(mem_Read), 32'h0);
        chk("rst_mem_wr", 32'(mem_Write), 32'h0);
        chk("rst_if_data", if_Read_data, 32'h0);
        chk("rst_d_data", d_Read_data, 32'h0);
        chk("rst_terr", 32'(timeout_err), 32'h0);
        @(posedge Clock);
        #1 Reset = 1'b1;

        // Lone fetch: one memory cycle, response seen on 3rd edge
        @(posedge Clock);
        #1;
        a0 = acc_cyc;
        push(1'b0, 1'b1, 32'h1234_5678);
        if_Address = 32'h40;
        if_Read    = 1'b1;
        wait_resp(1'b0, t);
        chk("fetch_latency", 32'(t), 32'd3);
        chk("fetch_mem_cyc", 32'(acc_cyc - a0), 32'd1);
        chk("fetch_func3", 32'(last_f3), 32'(3'b010));
        @(posedge Clock);
        #1 if_Read = 1'b0;

        // Simultaneous store and fetch: data port first
        @(posedge Clock);
        #1;
        push(1'b1, 1'b0, 32'h0);
        push(1'b0, 1'b1, 32'h0BAD_F00D);
        fork
            drv_wr(32'h80, 32'hDEAD_BEEF);
            drv_rd(1'b0, 1, 32'h44, 3'b010);
        join
        chk("sw_mem", mem[32], 32'hDEAD_BEEF);
        push(1'b1, 1'b1, 32'hDEAD_BEEF);
        drv_rd(1'b1, 1, 32'h80, 3'b100);
        chk("d_func3", 32'(last_f3), 32'(3'b100));

        // Fetch with memory wait states
        wait_states = 3;
        a0 = acc_cyc;
        push(1'b0, 1'b1, 32'h0BAD_F00D);
        drv_rd(1'b0, 1, 32'h44, 3'b010);
        chk("wait_mem_cyc", 32'(acc_cyc - a0), 32'd4);
        wait_states = 0;

        // Both ports streaming three reads each
`ifdef MEM_ARB_ROUND_ROBIN_EN
        push(1'b1, 1'b1, 32'hA000_0020);
        push(1'b0, 1'b1, 32'hB000_0000);
        push(1'b1, 1'b1, 32'hA000_0024);
        push(1'b0, 1'b1, 32'hB000_0004);
        push(1'b1, 1'b1, 32'hA000_0028);
        push(1'b0, 1'b1, 32'hB000_0008);
`else
        push(1'b1, 1'b1, 32'hA000_0020);
        push(1'b1, 1'b1, 32'hA000_0024);
        push(1'b1, 1'b1, 32'hA000_0028);
        push(1'b0, 1'b1, 32'hB000_0000);
        push(1'b0, 1'b1, 32'hB000_0004);
        push(1'b0, 1'b1, 32'hB000_0008);
`endif
        fork
            drv_rd(1'b1, 3, 32'h20, 3'b010);
            drv_rd(1'b0, 3, 32'h00, 3'b010);
        join

        // Memory stalls forever: timeout after 64 access cycles
        force_busy = 1'b1;
        a0 = acc_cyc;
        push(1'b1, 1'b1, 32'h0);
        drv_rd(1'b1, 1, 32'h30, 3'b010);
        force_busy = 1'b0;
        chk("tmo_cycles", 32'(acc_cyc - a0), 32'd64);
        chk("tmo_err", 32'(timeout_err), 32'h1);
        @(negedge Clock);
        chk("tmo_idle", 32'(mem_Read | mem_Write), 32'h0);
        push(1'b1, 1'b1, 32'h5555_AAAA);
        drv_rd(1'b1, 1, 32'h30, 3'b010);
        chk("tmo_sticky", 32'(timeout_err), 32'h1);

        // Reset in the middle of an access
        force_busy = 1'b1;
        @(posedge Clock);
        #1;
        d_Address = 32'h40;
        d_Func3   = 3'b010;
        d_Read    = 1'b1;
        repeat (2) @(negedge Clock);
        chk("rst_pre_acc", 32'(mem_Read), 32'h1);
        #1 Reset = 1'b0;
        #1;
        chk("rst_abort", 32'(mem_Read | mem_Write), 32'h0);
        chk("rst_terr_clr", 32'(timeout_err), 32'h0);
        chk("rst_d_clr", d_Read_data, 32'h0);
        d_Read     = 1'b0;
        force_busy = 1'b0;
        @(posedge Clock);
        #1 Reset = 1'b1;
        push(1'b1, 1'b1, 32'h1234_5678);
        drv_rd(1'b1, 1, 32'h40, 3'b010);

        // Data port walks away mid-access; fetch is served next
        force_busy = 1'b1;
        @(posedge Clock);
        #1;
        d_Address = 32'h34;
        d_Read    = 1'b1;
        repeat (2) @(negedge Clock);
        chk("drop_in_acc", 32'(mem_Read), 32'h1);
        #1;
        d_Read     = 1'b0;
        if_Address = 32'h48;
        if_Read    = 1'b1;
        push(1'b0, 1'b1, 32'h0C0F_FEE0);
        @(negedge Clock);
        chk("drop_kept", 32'(mem_Read), 32'h1);
        chk("drop_addr", mem_Address, 32'h34);
        chk("drop_busy", 32'(d_busywait), 32'h0);
        force_busy = 1'b0;
        wait_resp(1'b0, t);
        @(posedge Clock);
        #1 if_Read = 1'b0;

        repeat (3) @(negedge Clock);
        chk("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
